// File: rtl/multicycle_controller.sv
// multicycle_controller: multicycle RISC-V control FSM with memory wait states,
// registered Moore controls and saturating performance counters.
module multicycle_controller #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             Zero,
    input  logic             MemReady,
    output logic             PCWrite,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             AdrSrc,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ImmSrc,
    output logic [2:0]       ALUControl,
    output logic             Halt,
    output logic [3:0]       State,
    output logic [CNT_W-1:0] CycleCount,
    output logic [CNT_W-1:0] InstrCount
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        ALUWB    = 4'd7,
        EXECUTEI = 4'd8,
        JAL      = 4'd9,
        BEQ      = 4'd10,
        HALT     = 4'd11
    } state_e;

    typedef struct packed {
        logic       adr_src;
        logic       reg_write;
        logic       mem_write;
        logic       fetch;
        logic       pc_upd;
        logic       branch;
        logic       halt;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctl_t;

    state_e           state_q, state_d;
    ctl_t             ctl_q;
    logic [CNT_W-1:0] cycle_q, instr_q;
    logic [2:0]       r_ctl;

    function automatic ctl_t ctl_of(state_e s);
        ctl_t c;
        c = '0;
        case (s)
            FETCH:    begin c.fetch = 1'b1; c.alu_src_b = 2'b10; c.result_src = 2'b10; end
            DECODE:   begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; end
            MEMADR:   begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; end
            MEMREAD:  c.adr_src = 1'b1;
            MEMWB:    begin c.result_src = 2'b01; c.reg_write = 1'b1; end
            MEMWRITE: begin c.adr_src = 1'b1; c.mem_write = 1'b1; end
            EXECUTER: begin c.alu_src_a = 2'b10; c.alu_op = 2'b10; end
            EXECUTEI: begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.alu_op = 2'b10; end
            ALUWB:    c.reg_write = 1'b1;
            JAL:      begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.pc_upd = 1'b1; end
            BEQ:      begin c.alu_src_a = 2'b10; c.alu_op = 2'b01; c.branch = 1'b1; end
            HALT:     c.halt = 1'b1;
            default:  c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:    state_d = MemReady ? DECODE : FETCH;
            DECODE:
                case (op)
                    7'b0000011, 7'b0100011: state_d = MEMADR;
                    7'b0110011:             state_d = EXECUTER;
                    7'b0010011:             state_d = EXECUTEI;
                    7'b1101111:             state_d = JAL;
                    7'b1100011:             state_d = BEQ;
                    default:                state_d = HALT;
                endcase
            MEMADR:   state_d = (op == 7'b0100011) ? MEMWRITE : MEMREAD;
            MEMREAD:  state_d = MemReady ? MEMWB : MEMREAD;
            MEMWRITE: state_d = MemReady ? FETCH : MEMWRITE;
            MEMWB, ALUWB, BEQ:         state_d = FETCH;
            EXECUTER, EXECUTEI, JAL:   state_d = ALUWB;
            HALT:     state_d = HALT;
            default:  state_d = FETCH;
        endcase
    end

    // Controls are registered from the next state so they are glitch-free Moore outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            ctl_q   <= ctl_of(FETCH);
            cycle_q <= '0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            ctl_q   <= ctl_of(state_d);
            if (state_q != HALT && !(&cycle_q))
                cycle_q <= cycle_q + CNT_W'(1);
            if (state_q == FETCH && MemReady && !(&instr_q))
                instr_q <= instr_q + CNT_W'(1);
        end
    end

    always_comb begin
        r_ctl = funct3 == 3'b000 ? ((op[5] & funct7b5) ? 3'b001 : 3'b000) :
                funct3 == 3'b010 ? 3'b101 :
                funct3 == 3'b110 ? 3'b011 :
                funct3 == 3'b111 ? 3'b010 : 3'b000;
        ALUControl = ctl_q.alu_op == 2'b01 ? 3'b001 :
                     ctl_q.alu_op == 2'b10 ? r_ctl : 3'b000;
        ImmSrc = op == 7'b0100011 ? 2'b01 :
                 op == 7'b1100011 ? 2'b10 :
                 op == 7'b1101111 ? 2'b11 : 2'b00;
    end

    // Reset gates the MemReady/Zero driven enables so nothing fires while reset is held.
    assign IRWrite    = ~reset & ctl_q.fetch & MemReady;
    assign PCWrite    = ~reset & (ctl_q.pc_upd | (ctl_q.fetch & MemReady) | (ctl_q.branch & Zero));
    assign RegWrite   = ctl_q.reg_write;
    assign MemWrite   = ctl_q.mem_write;
    assign AdrSrc     = ctl_q.adr_src;
    assign ResultSrc  = ctl_q.result_src;
    assign ALUSrcA    = ctl_q.alu_src_a;
    assign ALUSrcB    = ctl_q.alu_src_b;
    assign Halt       = ctl_q.halt;
    assign State      = state_q;
    assign CycleCount = cycle_q;
    assign InstrCount = instr_q;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: random instruction stream against a path-table model,
// with a second 4-bit-counter instance to exercise counter saturation.
module tb_multicycle_controller;
    logic        clk, reset, funct7b5, zero, mem_ready;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        pcw, irw, regw, memw, adr, halt;
    logic [1:0]  res, srca, srcb, imm;
    logic [2:0]  alu;
    logic [3:0]  state;
    logic [31:0] cyc_o, ins_o;
    logic        s_pcw, s_irw, s_regw, s_memw, s_adr, s_halt;
    logic [1:0]  s_res, s_srca, s_srcb, s_imm;
    logic [2:0]  s_alu;
    logic [3:0]  s_state;
    logic [3:0]  s_cyc, s_ins;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(zero), .MemReady(mem_ready), .PCWrite(pcw), .IRWrite(irw),
        .RegWrite(regw), .MemWrite(memw), .AdrSrc(adr), .ResultSrc(res),
        .ALUSrcA(srca), .ALUSrcB(srcb), .ImmSrc(imm), .ALUControl(alu),
        .Halt(halt), .State(state), .CycleCount(cyc_o), .InstrCount(ins_o)
    );

    multicycle_controller #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(zero), .MemReady(mem_ready), .PCWrite(s_pcw), .IRWrite(s_irw),
        .RegWrite(s_regw), .MemWrite(s_memw), .AdrSrc(s_adr), .ResultSrc(s_res),
        .ALUSrcA(s_srca), .ALUSrcB(s_srcb), .ImmSrc(s_imm), .ALUControl(s_alu),
        .Halt(s_halt), .State(s_state), .CycleCount(s_cyc), .InstrCount(s_ins)
    );

    typedef struct packed {
        logic       adr, regw, memw;
        logic [1:0] res, a, b, aop;
        logic       halt;
    } exp_t;

    int     n_checks = 0, n_fail = 0;
    int     path[$];
    int     idx, halt_cycles;
    longint cyc, ins;
    bit     new_instr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Each opcode walks a fixed list of states; wait states repeat in place.
    function automatic void set_path(logic [6:0] o);
        case (o)
            7'b0000011: path = '{0, 1, 2, 3, 4};
            7'b0100011: path = '{0, 1, 2, 5};
            7'b0110011: path = '{0, 1, 6, 7};
            7'b0010011: path = '{0, 1, 8, 7};
            7'b1101111: path = '{0, 1, 9, 7};
            7'b1100011: path = '{0, 1, 10};
            default:    path = '{0, 1, 11};
        endcase
    endfunction

    function automatic exp_t moore(int s);
        exp_t e;
        case (s)
            0:       e = 12'b0_0_0_10_00_10_00_0;
            1:       e = 12'b0_0_0_00_01_01_00_0;
            2:       e = 12'b0_0_0_00_10_01_00_0;
            3:       e = 12'b1_0_0_00_00_00_00_0;
            4:       e = 12'b0_1_0_01_00_00_00_0;
            5:       e = 12'b1_0_1_00_00_00_00_0;
            6:       e = 12'b0_0_0_00_10_00_10_0;
            7:       e = 12'b0_1_0_00_00_00_00_0;
            8:       e = 12'b0_0_0_00_10_01_10_0;
            9:       e = 12'b0_0_0_00_01_10_00_0;
            10:      e = 12'b0_0_0_00_10_00_01_0;
            default: e = 12'b0_0_0_00_00_00_00_1;
        endcase
        return e;
    endfunction

    function automatic logic [2:0] alu_exp(logic [1:0] aop);
        if (aop == 2'b00) return 3'b000;
        if (aop == 2'b01) return 3'b001;
        case (funct3)
            3'b000:  return (op[5] && funct7b5) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [1:0] imm_exp(logic [6:0] o);
        case (o)
            7'b0100011: return 2'b01;
            7'b1100011: return 2'b10;
            7'b1101111: return 2'b11;
            default:    return 2'b00;
        endcase
    endfunction

    task automatic model_reset();
        idx = 0; cyc = 0; ins = 0; new_instr = 1; halt_cycles = 0;
    endtask

    task automatic advance();
        int cur = path[idx];
        if (cur != 11) cyc++;
        if (cur == 0 && mem_ready) ins++;
        if (cur != 11 && !((cur == 0 || cur == 3 || cur == 5) && !mem_ready)) begin
            idx++;
            if (idx == path.size()) begin
                idx = 0;
                new_instr = 1;
            end
        end
    endtask

    task automatic check_outputs();
        int         cur = path[idx];
        exp_t       e = moore(cur);
        logic       e_irw = (cur == 0) && mem_ready;
        logic       e_pcw = e_irw || cur == 9 || (cur == 10 && zero);
        logic [2:0] e_alu = alu_exp(e.aop);
        logic [1:0] e_imm = imm_exp(op);
        check("state", state, cur);
        check("pcwrite", pcw, e_pcw);
        check("irwrite", irw, e_irw);
        check("regwrite", regw, e.regw);
        check("memwrite", memw, e.memw);
        check("adrsrc", adr, e.adr);
        check("resultsrc", res, e.res);
        check("alusrca", srca, e.a);
        check("alusrcb", srcb, e.b);
        check("immsrc", imm, e_imm);
        check("alucontrol", alu, e_alu);
        check("halt", halt, e.halt);
        check("cyclecount", cyc_o, cyc);
        check("instrcount", ins_o, ins);
        check("w4_ctl", {s_pcw, s_irw, s_regw, s_memw, s_adr, s_res, s_srca, s_srcb, s_imm, s_alu, s_halt, s_state},
              {e_pcw, e_irw, e.regw, e.memw, e.adr, e.res, e.a, e.b, e_imm, e_alu, e.halt, 4'(cur)});
        check("w4_cyclecount", s_cyc, cyc > 15 ? 15 : cyc);
        check("w4_instrcount", s_ins, ins > 15 ? 15 : ins);
    endtask

    task automatic reset_checks();
        check("rst_state", {state, s_state}, 8'h00);
        check("rst_counts", {cyc_o, ins_o, s_cyc, s_ins}, 72'h0);
        check("rst_enables", {halt, memw, regw, pcw, irw, s_halt, s_memw, s_regw, s_pcw, s_irw}, 10'h0);
    endtask

    // Asserted away from the clock edge so the clear is seen before any edge arrives.
    task automatic do_reset();
        mem_ready = 1'b1;
        zero = 1'b1;
        reset = 1'b1;
        #1;
        reset_checks();
        @(posedge clk);
        #1;
        reset_checks();
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [6:0] ops [6] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111, 7'b1100011};
        logic [6:0] bad [3] = '{7'b1111111, 7'b0000000, 7'b0110111};
        reset = 1'b1; op = 7'b0000011; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b1; mem_ready = 1'b1;
        #1;
        reset_checks();
        @(posedge clk);
        #1;
        reset_checks();
        reset = 1'b0;
        model_reset();
        for (int c = 0; c < 4000; c++) begin
            if (new_instr) begin
                op = ($urandom_range(0, 9) == 0) ? bad[$urandom_range(0, 2)] : ops[$urandom_range(0, 5)];
                set_path(op);
                new_instr = 0;
            end
            funct3    = 3'($urandom);
            funct7b5  = 1'($urandom);
            zero      = 1'($urandom);
            mem_ready = $urandom_range(0, 3) != 0;
            @(negedge clk);
            check_outputs();
            @(posedge clk);
            advance();
            #1;
            if (path[idx] == 11) halt_cycles++;
            if (halt_cycles > 3 || $urandom_range(0, 199) == 0) do_reset();
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
